// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program-counter sequencer for the instruction-fetch
// front end. Runs at a slow or fast rate using a synchronous tick-enable divider,
// supports single-step, stop, datapath halt and a saturating retired counter.
// Optional address breakpoint enabled by defining PC_SEQ_BREAKPOINT_EN.
module pc_sequencer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIV_SLOW = 25000000,
   parameter int unsigned DIV_FAST = 250000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             run,
   input  logic             speedrun,
   input  logic             stop,
   input  logic             step_req,
   input  logic             halt,
   input  logic [WIDTH-1:0] step,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   input  logic             bp_en,
   input  logic [WIDTH-1:0] bp_addr,
   output logic [WIDTH-1:0] pc,
   output logic             tick,
   output logic             running,
   output logic             fast,
   output logic             bp_hit,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
   localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BREAK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             fast_q, fast_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             tick_q, tick_d;
   logic             adv_c;
   logic             bp_match_c;
   logic [DIV_W-1:0] div_last_c;

`ifdef PC_SEQ_BREAKPOINT_EN
   logic             skip_q, skip_d;

   // Breakpoint fires on a RUN advance edge unless we are just resuming from it.
   assign bp_match_c = bp_en && (pc_q == bp_addr) && !skip_q;
`else
   logic             bp_unused;

   // Breakpoint inputs have no effect in this build.
   assign bp_unused  = bp_en ^ (^bp_addr);
   assign bp_match_c = 1'b0;
`endif

   assign div_last_c = fast_q ? FAST_LAST : SLOW_LAST;

   // State, divider and rate registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         fast_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         fast_q  <= fast_d;
      end
   end

`ifdef PC_SEQ_BREAKPOINT_EN
   // Resume-skip flag for the breakpoint.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skip_q <= 1'b0;
      end else begin
         skip_q <= skip_d;
      end
   end
`endif

   // Datapath registers: program counter, retired counter and advance strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= '0;
         retired_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         retired_q <= retired_d;
         tick_q    <= tick_d;
      end
   end

   // Command decode in priority order, divider and advance decision.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      fast_d  = fast_q;
      adv_c   = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
      skip_d  = skip_q;
`endif
      if (stop) begin
         state_d = ST_IDLE;
         div_d   = '0;
`ifdef PC_SEQ_BREAKPOINT_EN
         skip_d  = 1'b0;
`endif
      end else if (speedrun || run) begin
         state_d = ST_RUN;
         fast_d  = speedrun;
         div_d   = '0;
`ifdef PC_SEQ_BREAKPOINT_EN
         if (state_q == ST_BREAK) begin
            skip_d = 1'b1;
         end
`endif
      end else if (step_req && (state_q != ST_RUN)) begin
         // Single step: the step itself is the first advance after any resume.
         adv_c = 1'b1;
`ifdef PC_SEQ_BREAKPOINT_EN
         skip_d = 1'b0;
`endif
      end else if (state_q == ST_RUN) begin
         if (div_q == div_last_c) begin
            div_d = '0;
            if (bp_match_c) begin
               state_d = ST_BREAK;
            end else begin
               adv_c = 1'b1;
`ifdef PC_SEQ_BREAKPOINT_EN
               skip_d = 1'b0;
`endif
               if (halt) begin
                  state_d = ST_IDLE;
               end
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   // Advance effects on pc, retired counter and tick.
   always_comb begin
      pc_d      = pc_q;
      retired_d = retired_q;
      tick_d    = 1'b0;
      if (adv_c) begin
         pc_d   = load_en ? load_value : (pc_q + step);
         tick_d = 1'b1;
         if (retired_q != {CNT_W{1'b1}}) begin
            retired_d = retired_q + CNT_W'(1);
         end
      end
   end

   assign pc      = pc_q;
   assign tick    = tick_q;
   assign retired = retired_q;
   assign fast    = fast_q;
   assign running = (state_q == ST_RUN);
`ifdef PC_SEQ_BREAKPOINT_EN
   assign bp_hit  = (state_q == ST_BREAK);
`else
   assign bp_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus
// against a countdown-based behavioural model with an advance scoreboard.
module tb_pc_sequencer;

   localparam int unsigned W   = 8;
   localparam int unsigned DS  = 2;
   localparam int unsigned DF  = 4;
   localparam int unsigned CW  = 3;
   localparam int          RMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, run, speedrun, stop, step_req, halt, load_en, bp_en;
   logic [W-1:0]  step, load_value, bp_addr, pc;
   logic          tick, running, fast, bp_hit;
   logic [CW-1:0] retired;

   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(W), .DIV_SLOW(DS), .DIV_FAST(DF), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .speedrun(speedrun), .stop(stop),
      .step_req(step_req), .halt(halt), .step(step), .load_en(load_en),
      .load_value(load_value), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .tick(tick), .running(running), .fast(fast), .bp_hit(bp_hit),
      .retired(retired)
   );

   typedef enum {M_IDLE, M_RUN, M_BREAK} mode_t;
   typedef struct {
      logic [W-1:0] pc;
      int           ret;
   } exp_t;

   exp_t  sb_q[$];
   int    n_total = 0;
   int    n_pass  = 0;

   mode_t        m_mode;
   logic [W-1:0] m_pc;
   int           m_ret;
   int           m_left;
   bit           m_fast, m_skip, m_tick;
`ifdef PC_SEQ_BREAKPOINT_EN
   localparam bit BP_ON = 1'b1;
`else
   localparam bit BP_ON = 1'b0;
`endif

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_pc = '0; m_ret = 0; m_left = 0;
      m_fast = 1'b0; m_skip = 1'b0; m_tick = 1'b0;
   endtask

   task automatic model_advance();
      exp_t e;
      m_pc = load_en ? load_value : W'(m_pc + step);
      if (m_ret < RMAX) m_ret++;
      m_tick = 1'b1;
      e.pc = m_pc; e.ret = m_ret;
      sb_q.push_back(e);
   endtask

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_edge();
      m_tick = 1'b0;
      if (stop) begin
         m_mode = M_IDLE; m_skip = 1'b0;
      end else if (speedrun || run) begin
         if (m_mode == M_BREAK) m_skip = 1'b1;
         m_mode = M_RUN;
         m_fast = speedrun;
         m_left = speedrun ? DF : DS;
      end else if (step_req && m_mode != M_RUN) begin
         model_advance();
         m_skip = 1'b0;
      end else if (m_mode == M_RUN) begin
         m_left--;
         if (m_left == 0) begin
            m_left = m_fast ? DF : DS;
            if (BP_ON && bp_en && m_pc == bp_addr && !m_skip) begin
               m_mode = M_BREAK;
            end else begin
               model_advance();
               m_skip = 1'b0;
               if (halt) m_mode = M_IDLE;
            end
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk); #1;
      chk("tick", tick, m_tick);
      chk("pc", pc, m_pc);
      chk("retired", retired, m_ret);
      chk("running", running, m_mode == M_RUN);
      chk("fast", fast, m_fast);
      chk("bp_hit", bp_hit, m_mode == M_BREAK);
      @(negedge clk);
      run = 0; speedrun = 0; stop = 0; step_req = 0;
   endtask

   // Assert reset away from the clock edge and check outputs clear at once.
   task automatic reset_dut();
      rst = 1'b0;
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_retired", retired, 0);
      chk("rst_tick", tick, 0);
      chk("rst_running", running, 0);
      chk("rst_fast", fast, 0);
      chk("rst_bp_hit", bp_hit, 0);
      model_reset();
      sb_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Scoreboard monitor: every tick must match the next predicted advance.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (rst && tick) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected_tick: got pc %0d expected no advance", pc);
            end else begin
               e = sb_q.pop_front();
               chk("sb_pc", pc, e.pc);
               chk("sb_retired", retired, e.ret);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; run = 0; speedrun = 0; stop = 0; step_req = 0; halt = 0;
      load_en = 0; bp_en = 0; step = 8'd1; load_value = '0; bp_addr = '0;
      #1;
      reset_dut();

      // Speed run, step 3: 0 -> 3 -> 6 -> 9, one advance every 4 cycles.
      step = 8'd3; speedrun = 1;
      cycle();
      repeat (12) cycle();
      chk("s1_pc", pc, 9);
      chk("s1_retired", retired, 3);

      // Wrap-around by single step from 0xFE with step 5.
      stop = 1; cycle();
      load_en = 1; load_value = 8'hFE; step_req = 1; cycle();
      load_en = 0; step = 8'd5; step_req = 1; cycle();
      chk("s2_pc", pc, 8'h03);
      chk("s2_running", running, 0);

      // Jump to 0x40 on one advance, halt on the next.
      reset_dut();
      step = 8'd1; run = 1; cycle();
      cycle();
      load_en = 1; load_value = 8'h40; cycle();
      chk("s3_jump", pc, 8'h40);
      load_en = 0; cycle();
      halt = 1; cycle();
      halt = 0;
      chk("s3_pc", pc, 8'h41);
      chk("s3_running", running, 0);

      // Breakpoint at 0x05 then resume.
      reset_dut();
      step = 8'd1; bp_en = 1; bp_addr = 8'h05; run = 1; cycle();
      repeat (13) cycle();
      chk("s4_pc", pc, BP_ON ? 5 : 6);
      chk("s4_bp_hit", bp_hit, BP_ON ? 1 : 0);
      run = 1; cycle();
      repeat (2) cycle();
      chk("s4_resume_pc", pc, BP_ON ? 6 : 7);
      repeat (6) cycle();
      bp_en = 0;

      // Stop coinciding with an advance edge.
      reset_dut();
      run = 1; cycle();
      cycle();
      stop = 1; cycle();
      chk("s5_pc", pc, 0);
      chk("s5_tick", tick, 0);
      chk("s5_running", running, 0);

      // Retired counter saturation, then asynchronous reset mid-run.
      reset_dut();
      repeat (9) begin step_req = 1; cycle(); end
      chk("s6_retired", retired, RMAX);
      run = 1; cycle();
      cycle();
      reset_dut();

      // Randomized commands and data.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) < 3) reset_dut();
         stop       = ($urandom_range(99) < 3);
         speedrun   = ($urandom_range(99) < 3);
         run        = ($urandom_range(99) < 4);
         step_req   = ($urandom_range(99) < 12);
         halt       = ($urandom_range(99) < 6);
         load_en    = ($urandom_range(99) < 15);
         step       = ($urandom_range(3) == 0) ? W'($urandom) : W'($urandom_range(3));
         load_value = W'($urandom);
         bp_en      = ($urandom_range(1) == 1);
         bp_addr    = W'(m_pc + W'($urandom_range(3)));
         cycle();
      end

      #3;
      chk("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
